// File: rtl/debounce_edge_if.sv
// Pushbutton conditioning bus: raw input toward the debouncer, clean level,
// edge pulses and qualification status back from it.
interface debounce_edge_if;
  logic btn_in;
  logic btn_out;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output btn_in,
    input  btn_out,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_out,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/debounce_edge.sv
// Pushbutton/switch debouncer: 2-FF synchronizer, stability counter and a
// 4-state qualification FSM producing a registered level plus rise/fall pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_LOW  | output level 0, waiting for the synchronized input to go 1
// WAIT_HIGH | input is 1, counting stable cycles before accepting it
// IDLE_HIGH | output level 1, waiting for the synchronized input to go 0
// WAIT_LOW  | input is 0, counting stable cycles before accepting it
module debounce_edge #(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            arst,
  debounce_edge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count; legal parameters guarantee STABLE_CYCLES-1 fits in CNT_W.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_out;
  logic             r_rise;
  logic             r_fall;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_btn_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and registered outputs; reset clears without emitting a pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_btn_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_btn_out <= w_btn_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
    end
  end

  // Next-state logic: any opposite sample while waiting aborts with no partial credit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_btn_nxt   = r_btn_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = IDLE_HIGH;
          w_btn_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = IDLE_LOW;
          w_btn_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.btn_out = r_btn_out;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.busy    = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: one instance with STABLE_CYCLES=4 and one with
// STABLE_CYCLES=1, checked every cycle against a run-length model plus
// directed literal expectations.
module tb_debounce_edge;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  debounce_edge_if bus0();
  debounce_edge_if bus1();

  debounce_edge #(.CNT_W(3), .STABLE_CYCLES(4)) dut0 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus0)
  );

  debounce_edge #(.CNT_W(3), .STABLE_CYCLES(1)) dut1 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: the level flips once the FSM has seen STABLE_CYCLES+1 consecutive
  // samples that disagree with it (one to notice, then STABLE_CYCLES to hold).
  // The FSM's view of btn_in lags by two edges of sampling.
  int   s_cyc [2] = '{4, 1};
  logic m_h1    [2];
  logic m_h2    [2];
  logic m_lvl   [2];
  logic m_rise  [2];
  logic m_fall  [2];
  int   m_run   [2];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge arst) begin
    logic b [2];
    logic v;
    b[0] = bus0.btn_in;
    b[1] = bus1.btn_in;
    for (int i = 0; i < 2; i++) begin
      if (arst) begin
        m_h1[i] = 1'b0; m_h2[i] = 1'b0; m_lvl[i] = 1'b0;
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
      end else begin
        v = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = b[i];
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (v !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == s_cyc[i] + 1) begin
            m_lvl[i]  = v;
            m_run[i]  = 0;
            m_rise[i] = v;
            m_fall[i] = ~v;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !arst) begin
      chk("dut0_btn_out", bus0.btn_out, m_lvl[0]);
      chk("dut0_rise",    bus0.rise,    m_rise[0]);
      chk("dut0_fall",    bus0.fall,    m_fall[0]);
      chk("dut0_busy",    bus0.busy,    m_run[0] != 0);
      chk("dut1_btn_out", bus1.btn_out, m_lvl[1]);
      chk("dut1_rise",    bus1.rise,    m_rise[1]);
      chk("dut1_fall",    bus1.fall,    m_fall[1]);
      chk("dut1_busy",    bus1.busy,    m_run[1] != 0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_btn_out0"}, bus0.btn_out, 1'b0);
    chk({tag, "_rise0"},    bus0.rise,    1'b0);
    chk({tag, "_fall0"},    bus0.fall,    1'b0);
    chk({tag, "_busy0"},    bus0.busy,    1'b0);
    chk({tag, "_btn_out1"}, bus1.btn_out, 1'b0);
    chk({tag, "_busy1"},    bus1.busy,    1'b0);
  endtask

  initial begin
    bus0.btn_in = 1'b0;
    bus1.btn_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("in_reset");
    #1 arst = 1'b0;
    cmp_en = 1'b1;

    // Clean press on dut0, edge k is the next posedge.
    @(negedge clk); bus0.btn_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("press_busy_k2",    bus0.busy,    1'b1);
    chk("press_out_k2",     bus0.btn_out, 1'b0);
    repeat (3) @(negedge clk);
    chk("press_rise_k5",    bus0.rise,    1'b0);
    @(negedge clk);
    chk("press_out_k6",     bus0.btn_out, 1'b1);
    chk("press_rise_k6",    bus0.rise,    1'b1);
    chk("press_busy_k6",    bus0.busy,    1'b0);
    chk("model_rise_k6",    m_rise[0],    1'b1);
    @(negedge clk);
    chk("press_rise_k7",    bus0.rise,    1'b0);
    chk("press_out_k7",     bus0.btn_out, 1'b1);

    // Clean release on dut0.
    @(negedge clk); bus0.btn_in = 1'b0;
    repeat (7) @(negedge clk);
    chk("rel_out_k6",       bus0.btn_out, 1'b0);
    chk("rel_fall_k6",      bus0.fall,    1'b1);
    chk("model_fall_k6",    m_fall[0],    1'b1);
    @(negedge clk);
    chk("rel_fall_k7",      bus0.fall,    1'b0);
    chk("rel_rise_k7",      bus0.rise,    1'b0);

    // Bounce: high at k, k+1, low from k+2 to k+4, then high from m=k+5.
    @(negedge clk); bus0.btn_in = 1'b1;
    @(negedge clk);
    @(negedge clk); bus0.btn_in = 1'b0;
    @(negedge clk);
    chk("bounce_busy_k2",   bus0.busy,    1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("bounce_busy_k4",   bus0.busy,    1'b0);
    chk("bounce_out_k4",    bus0.btn_out, 1'b0);
    bus0.btn_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("bounce_out_m5",    bus0.btn_out, 1'b0);
    chk("bounce_rise_m5",   bus0.rise,    1'b0);
    @(negedge clk);
    chk("bounce_rise_m6",   bus0.rise,    1'b1);
    chk("bounce_out_m6",    bus0.btn_out, 1'b1);

    // Async reset while btn_out=1, asserted between edges.
    @(negedge clk);
    #2 arst = 1'b1;
    #1 chk_all_zero("async_rst");
    bus0.btn_in = 1'b0;
    @(negedge clk); #1 arst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_out",     bus0.btn_out, 1'b0);
    chk("post_rst_fall",    bus0.fall,    1'b0);

    // Reset mid-count: WAIT_HIGH with cnt=2 after k+4.
    @(negedge clk); bus0.btn_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("midcnt_busy_k4",   bus0.busy,    1'b1);
    #2 arst = 1'b1;
    #1 chk("midcnt_rst_busy", bus0.busy,  1'b0);
    chk("midcnt_rst_out",   bus0.btn_out, 1'b0);
    @(negedge clk); #1 arst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midcnt_rise_j5",   bus0.rise,    1'b0);
    chk("midcnt_out_j5",    bus0.btn_out, 1'b0);
    @(negedge clk);
    chk("midcnt_rise_j6",   bus0.rise,    1'b1);
    chk("midcnt_out_j6",    bus0.btn_out, 1'b1);

    // STABLE_CYCLES=1 instance.
    @(negedge clk); bus1.btn_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("s1_busy_k2",       bus1.busy,    1'b1);
    chk("s1_out_k2",        bus1.btn_out, 1'b0);
    @(negedge clk);
    chk("s1_out_k3",        bus1.btn_out, 1'b1);
    chk("s1_rise_k3",       bus1.rise,    1'b1);
    chk("s1_busy_k3",       bus1.busy,    1'b0);
    chk("model_s1_rise_k3", m_rise[1],    1'b1);
    @(negedge clk);
    chk("s1_rise_k4",       bus1.rise,    1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditions a raw, asynchronous pushbutton or switch input into a clean registered level plus single-cycle rise and fall pulses.
- Sits directly upstream of the lab's D flip-flops, counters and enables; its btn_out or rise output drives their D or enable input.
- Contains a 2-FF synchronizer, a stability counter and a 4-state FSM.

Parameters:
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 50000, consecutive synchronized cycles the input must hold before a level change is accepted. Legal range: 1 <= STABLE_CYCLES <= 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- arst  in  1  asynchronous reset, active-high.
- btn_in  in  1  raw asynchronous input; may bounce.
- btn_out  out  1  debounced level, registered.
- rise  out  1  one-cycle pulse when btn_out goes 0->1, registered.
- fall  out  1  one-cycle pulse when btn_out goes 1->0, registered.
- busy  out  1  high while a candidate change is being qualified; decoded from the state register.

Behaviour:
- Reset:
  - While arst=1, without waiting for clk: sync1, sync2, cnt, btn_out, rise and fall are 0, and the state is IDLE_LOW, so busy=0.
  - Reset dominates every other event.
  - On release, the first rising clk edge resumes normal operation.
  - No pulse is generated by reset itself.
- Synchronizer: sync1<=btn_in, sync2<=sync1 on every edge. The FSM uses only sync2.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: if sync2=1, go to WAIT_HIGH with cnt<=0. Otherwise stay.
  - WAIT_HIGH:
    - If sync2=0 (bounce), go to IDLE_LOW with cnt<=0; btn_out unchanged.
    - Else if cnt==STABLE_CYCLES-1, go to IDLE_HIGH with btn_out<=1 and rise<=1.
    - Else cnt<=cnt+1.
  - IDLE_HIGH: if sync2=0, go to WAIT_LOW with cnt<=0.
  - WAIT_LOW: mirror of WAIT_HIGH. On sync2=1 return to IDLE_HIGH. On qualification, go to IDLE_LOW with btn_out<=0 and fall<=1.
- Pulses: rise and fall default to 0 each cycle, so each is high for exactly one cycle. Both are never high in the same cycle.
- Latency: let edge k be the first edge that samples a new stable btn_in value.
  - busy=1 after edge k+2.
  - btn_out and the pulse change after edge k+2+STABLE_CYCLES.
  - The pulse clears after edge k+3+STABLE_CYCLES.
  - busy=0 after edge k+2+STABLE_CYCLES.
- Counter:
  - Never exceeds STABLE_CYCLES-1, so no wrap can occur.
  - Width rule: compare against STABLE_CYCLES-1 truncated to CNT_W bits; legal parameters guarantee the value fits.
  - For STABLE_CYCLES=1, WAIT_* lasts exactly one cycle.
- Bounce: any opposite sample during WAIT_* aborts qualification. The counter restarts from 0 on the next qualifying transition; there is no partial credit.
- Reset mid-operation:
  - During WAIT_* the partial count is discarded.
  - If btn_in is held high across release, rise fires after the full latency measured from the first post-release edge.
  - If reset is asserted while btn_out=1, btn_out drops to 0 with no fall pulse.
- busy equals (state==WAIT_HIGH or state==WAIT_LOW).

Test Plan (STABLE_CYCLES=4, CNT_W=3 unless stated):
1. Async reset:
   - Stimulus: drive btn_in=1, run until btn_out=1, then assert arst between clock edges.
   - Required: btn_out, rise, fall and busy read 0 before the next edge, and fall never pulses.
2. Clean press:
   - Stimulus: btn_in 0->1, held, first sampled at edge k.
   - Required: busy=1 after k+2; btn_out=1, rise=1 and busy=0 after k+6; rise=0 after k+7; fall stays 0 throughout.
3. Bounce:
   - Stimulus: btn_in high for 2 edges (k, k+1), low at k+2, then high and stable from edge m.
   - Required: busy=1 after k+2, busy=0 after k+4, btn_out stays 0; final rise occurs after m+6 only.
4. Clean release:
   - Stimulus: from btn_out=1, btn_in 1->0 sampled at k.
   - Required: btn_out=0 and fall=1 after k+6; fall=0 after k+7; rise stays 0.
5. Reset mid-count:
   - Stimulus: pulse arst while in WAIT_HIGH with cnt=2, keep btn_in=1; first post-release edge is j.
   - Required: busy=0 immediately on assertion; rise pulses after j+6, not earlier.
6. STABLE_CYCLES=1:
   - Stimulus: btn_in 0->1 sampled at edge k.
   - Required: btn_out=1 and rise=1 after k+3; rise=0 after k+4.
